speed_ramp_controller: RTL and testbench

Sequences the `speed` input of the system clock divider so that frequency changes never jump. A requester asks for a target rate over a valid/ready handshake. The block then steps the divider's `speed` toward that target by at most `STEP` Hz at a time. Each step occurs only after `DWELL` rising edges of the divider's output clock. The block sits between user/control logic and the divider, owns the divider's `speed` port exclusively, and observes the divider's `outClk`.

---
 rtl/speed_ramp_controller.sv | 96 +++++++++
 tb/tb_speed_ramp_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/speed_ramp_controller.sv
// speed_ramp_controller: steps the divider speed toward a requested target at a bounded rate per dwell interval
module speed_ramp_controller #(
  parameter int BASE_SPEED = 50000000,
  parameter int MIN_SPEED  = 1,
  parameter int MAX_SPEED  = 1000000,
  parameter int STEP       = 1000,
  parameter int DWELL      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [19:0] req_speed,
  output logic        req_ready,
  input  logic        abort,
  input  logic        div_clk,
  output logic [19:0] speed,
  output logic        busy,
  output logic        done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [19:0] MIN_S = 20'(MIN_SPEED);
  localparam logic [19:0] MAX_S = 20'(MAX_SPEED);
  localparam logic [20:0] STEP_S = 21'(STEP);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  if (MIN_SPEED < 1 || STEP < 1 || DWELL < 1 || MAX_SPEED > 1048575 || MAX_SPEED > BASE_SPEED / 2 || MIN_SPEED > MAX_SPEED) begin : g_bad_params
    $error("speed_ramp_controller: illegal parameter set");
  end
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [19:0]   target;
  logic [19:0]   clamped;
  logic [19:0]   next_speed;
  logic          div_clk_q;
  logic          rise;
  logic          up;
  logic [20:0]   diff;
  logic [20:0]   delta;
  // request clamp, div_clk edge detect and the bounded, non-overshooting step toward target
  always_comb begin
    rise       = div_clk & ~div_clk_q;
    clamped    = req_speed < MIN_S ? MIN_S : req_speed > MAX_S ? MAX_S : req_speed;
    up         = target > speed;
    diff       = up ? {1'b0, target} - {1'b0, speed} : {1'b0, speed} - {1'b0, target};
    delta      = diff > STEP_S ? STEP_S : diff;
    next_speed = up ? speed + delta[19:0] : speed - delta[19:0];
  end
  // IDLE accepts targets; RAMP steps once every DWELL div_clk rises, abort wins over a step
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= MIN_S;
      div_clk_q <= 1'b0;
      speed     <= MIN_S;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
      done      <= 1'b0;
      if (state == IDLE) begin
        if (req_valid && req_ready) begin
          target <= clamped;
          if (clamped == speed) begin
            done <= 1'b1;
          end else begin
            state     <= RAMP;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            cnt       <= '0;
          end
        end
      end else if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        req_ready <= 1'b1;
        cnt       <= '0;
      end else if (rise) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          speed <= next_speed;
          if (next_speed == target) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_speed_ramp_controller.sv
// tb_speed_ramp_controller: scoreboard bench for the speed ramp sequencer
module tb_speed_ramp_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [19:0] req_speed = '0;
  logic        req_ready;
  logic        abort = 1'b0;
  logic        div_clk = 1'b0;
  logic [19:0] speed;
  logic        busy;
  logic        done;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_q[$];
  int          done_q[$];
  logic        mon_en = 1'b0;
  logic [19:0] prev_speed = '0;
  logic        prev_done = 1'b0;
  logic        tb_dq = 1'b0;

  speed_ramp_controller #(
    .MIN_SPEED(10), .MAX_SPEED(5000), .STEP(100), .DWELL(2)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_speed(req_speed),
    .req_ready(req_ready), .abort(abort), .div_clk(div_clk),
    .speed(speed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  initial begin
    #6;
    forever #30 div_clk = ~div_clk;
  end
  always @(posedge clk) tb_dq <= div_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (speed != prev_speed) begin
        if (exp_q.size() == 0) chk("step_extra", int'(speed), int'(prev_speed));
        else chk("step", int'(speed), exp_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_extra", 1, 0);
        else chk("done_speed", int'(speed), done_q.pop_front());
        chk("done_width", int'(prev_done), 0);
      end
    end
    prev_speed = speed;
    prev_done  = done;
  end

  task automatic send(input logic [19:0] v);
    int i;
    @(negedge clk);
    req_valid = 1'b1;
    req_speed = v;
    for (i = 0; i < 2000 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_speed", int'(speed), 10);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    exp_q = '{110, 210, 310, 350};
    done_q.push_back(350);
    send(20'd350);
    @(negedge clk);
    chk("up_busy", int'(busy), 1);
    chk("up_ready", int'(req_ready), 0);
    wait_done();
    chk("up_done_busy", int'(busy), 0);
    chk("up_done_ready", int'(req_ready), 1);
    @(negedge clk);
    chk("up_done_low", int'(done), 0);
    exp_q = '{250, 150, 50, 10};
    done_q.push_back(10);
    send(20'd0);
    wait_done();
    chk("clamp_lo", int'(speed), 10);
    for (int v = 110; v < 5000; v += 100) exp_q.push_back(v);
    exp_q.push_back(5000);
    done_q.push_back(5000);
    send(20'd9000);
    wait_done();
    chk("clamp_hi", int'(speed), 5000);
    done_q.push_back(5000);
    send(20'd5000);
    @(negedge clk);
    chk("noop_done", int'(done), 1);
    chk("noop_busy", int'(busy), 0);
    @(negedge clk);
    chk("noop_done_low", int'(done), 0);
    chk("noop_busy_low", int'(busy), 0);
    mon_en = 1'b0;
    send(20'd10);
    repeat (30) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_speed", int'(speed), 10);
    chk("mrst_busy", int'(busy), 0);
    @(negedge clk);
    chk("mrst_speed2", int'(speed), 10);
    chk("mrst_ready2", int'(req_ready), 1);
    chk("mrst_busy2", int'(busy), 0);
    chk("mrst_done2", int'(done), 0);
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    exp_q = '{110, 210};
    send(20'd350);
    for (int i = 0; i < 500 && speed != 20'd210; i++) @(negedge clk);
    chk("abort_reach", int'(speed), 210);
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(negedge clk);
      if (div_clk && !tb_dq) n++;
    end
    chk("abort_rises", n, 2);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_speed", int'(speed), 210);
    chk("abort_ready", int'(req_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (30) @(negedge clk);
    chk("abort_hold", int'(speed), 210);
    exp_q = '{310, 350, 250, 150, 50};
    done_q.push_back(350);
    done_q.push_back(50);
    send(20'd350);
    @(negedge clk);
    req_valid = 1'b1;
    req_speed = 20'd50;
    wait_done();
    chk("b2b_ready", int'(req_ready), 1);
    chk("b2b_speed", int'(speed), 350);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", int'(busy), 1);
    wait_done();
    chk("b2b_final", int'(speed), 50);
    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
